// File: rtl/target_hit_detector_pkg.sv
// Shared types and constants for the target hit detector.
package target_hit_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_CLEAR = 2'd1,
    ST_ARMED      = 2'd2,
    ST_HIT        = 2'd3
  } hit_state_t;

  localparam int NUM_PHOTO_DEFAULT = 10;
  localparam int DEBOUNCE_CNT_W    = 8;
  localparam int TARGET_W          = 4;
  localparam int TOTAL_W           = 16;

endpackage

// File: rtl/target_hit_detector_photo_debounce.sv
// One photo channel: 2-flop synchronizer followed by a stable-sample debounce counter.
module photo_debounce
  import target_hit_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam logic [DEBOUNCE_CNT_W-1:0] LIMIT = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES);

  logic                      sync1;
  logic                      sync2;
  logic [DEBOUNCE_CNT_W-1:0] cnt;

  // The counter only runs while the synced level disagrees with the clean level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt + 1'b1 == LIMIT) begin
        clean <= ~clean;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/target_hit_detector.sv
// Photo-array hit detector with two independent target FSMs.
// Define HIT_COUNTER_EN to add the saturating total_hits counter port.
module target_hit_detector
  import target_hit_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_PHOTO       = NUM_PHOTO_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PHOTO-1:0] photo_array,
  input  logic [TARGET_W-1:0]  target_a,
  input  logic [TARGET_W-1:0]  target_b,
  output logic [NUM_PHOTO-1:0] photo_clean,
  output logic                 hit_a,
  output logic                 hit_b,
  output logic                 hit_pulse_a,
  output logic                 hit_pulse_b,
  output logic [1:0]           state_a,
  output logic [1:0]           state_b
`ifdef HIT_COUNTER_EN
  ,
  output logic [TOTAL_W-1:0]   total_hits
`endif
);

  for (genvar i = 0; i < NUM_PHOTO; i++) begin : g_photo
    photo_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_photo_debounce (
      .clock(clock),
      .reset(reset),
      .raw  (photo_array[i]),
      .clean(photo_clean[i])
    );
  end

  logic [1:0]      hit_vec;
  logic [1:0]      pulse_vec;
  logic [1:0][1:0] state_vec;

  for (genvar g = 0; g < 2; g++) begin : g_fsm
    logic [TARGET_W-1:0] tgt;
    logic [TARGET_W-1:0] prev;
    hit_state_t          st;
    hit_state_t          st_next;
    logic                hit_q;
    logic                hit_next;
    logic                pulse_q;
    logic                pulse_next;
    logic                change;
    logic                valid;
    logic                beam;

    assign tgt    = (g == 0) ? target_a : target_b;
    assign change = (tgt != prev);
    assign valid  = (int'(tgt) < NUM_PHOTO);

    always_comb begin
      beam = 1'b0;
      for (int i = 0; i < NUM_PHOTO; i++) begin
        if (int'(tgt) == i) beam = photo_clean[i];
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        prev    <= '0;
        st      <= ST_IDLE;
        hit_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        prev    <= tgt;
        st      <= st_next;
        hit_q   <= hit_next;
        pulse_q <= pulse_next;
      end
    end

    // A retarget overrides any hit seen in the same cycle.
    always_comb begin
      st_next    = st;
      hit_next   = hit_q;
      pulse_next = 1'b0;
      if (change) begin
        hit_next = 1'b0;
        st_next  = valid ? ST_WAIT_CLEAR : ST_IDLE;
      end else begin
        case (st)
          ST_IDLE: st_next = ST_IDLE;
          ST_WAIT_CLEAR: begin
            if (!beam) st_next = ST_ARMED;
          end
          ST_ARMED: begin
            if (beam) begin
              st_next    = ST_HIT;
              hit_next   = 1'b1;
              pulse_next = 1'b1;
            end
          end
          ST_HIT: st_next = ST_HIT;
          default: st_next = ST_IDLE;
        endcase
      end
    end

    assign hit_vec[g]   = hit_q;
    assign pulse_vec[g] = pulse_q;
    assign state_vec[g] = st;
  end

  assign hit_a       = hit_vec[0];
  assign hit_b       = hit_vec[1];
  assign hit_pulse_a = pulse_vec[0];
  assign hit_pulse_b = pulse_vec[1];
  assign state_a     = state_vec[0];
  assign state_b     = state_vec[1];

`ifdef HIT_COUNTER_EN
  logic [TOTAL_W:0] total_sum;

  assign total_sum = {1'b0, total_hits} + (TOTAL_W + 1)'(hit_pulse_a)
                   + (TOTAL_W + 1)'(hit_pulse_b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_hits <= '0;
    end else begin
      total_hits <= total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_target_hit_detector.sv
// Directed bench for target_hit_detector with DEBOUNCE_CYCLES=4, NUM_PHOTO=10.
module tb_target_hit_detector;
  import target_hit_detector_pkg::*;

  localparam int NP = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [NP-1:0] photo_array;
  logic [3:0]    target_a;
  logic [3:0]    target_b;
  logic [NP-1:0] photo_clean;
  logic          hit_a, hit_b, hit_pulse_a, hit_pulse_b;
  logic [1:0]    state_a, state_b;
`ifdef HIT_COUNTER_EN
  logic [15:0]   total_hits;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  target_hit_detector #(
    .DEBOUNCE_CYCLES(4),
    .NUM_PHOTO      (NP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .photo_array(photo_array),
    .target_a   (target_a),
    .target_b   (target_b),
    .photo_clean(photo_clean),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .hit_pulse_a(hit_pulse_a),
    .hit_pulse_b(hit_pulse_b),
    .state_a    (state_a),
    .state_b    (state_b)
`ifdef HIT_COUNTER_EN
    ,
    .total_hits (total_hits)
`endif
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; photo_array = '0; target_a = 4'd0; target_b = 4'd0;
    tick(3);
    checks++;
    if ({photo_clean, hit_a, hit_b, hit_pulse_a, hit_pulse_b} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h expected 0", {photo_clean, hit_a, hit_b, hit_pulse_a, hit_pulse_b});
    end
    reset = 1'b1;
    tick(4);
    checks++;
    if ({state_a, state_b} !== {ST_IDLE, ST_IDLE}) begin
      errors++; $display("FAIL reset_zero_target_idle: got %0h expected 0", {state_a, state_b});
    end
`ifdef HIT_COUNTER_EN
    checks++;
    if (total_hits !== 16'd0) begin
      errors++; $display("FAIL reset_total: got %0h expected 0", total_hits);
    end
`endif
  endtask

  task automatic test_debounce();
    logic seen;
    photo_array[3] = 1'b1;
    tick(3);
    photo_array[3] = 1'b0;
    seen = 1'b0;
    repeat (10) begin tick(1); if (photo_clean[3]) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL debounce_glitch: got %0b expected 0", seen);
    end
    photo_array[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checks++;
      if (photo_clean[3] !== (k == 6)) begin
        errors++; $display("FAIL debounce_latency cycle %0d: got %0b expected %0b", k, photo_clean[3], (k == 6));
      end
    end
    photo_array[3] = 1'b0;
    tick(7);
    checks++;
    if (photo_clean !== '0) begin
      errors++; $display("FAIL debounce_fall: got %0h expected 0", photo_clean);
    end
  endtask

  task automatic test_basic_hit();
    target_a = 4'd5;
    tick(1);
    checks++;
    if ({state_a, hit_a} !== {ST_WAIT_CLEAR, 1'b0}) begin
      errors++; $display("FAIL basic_retarget: got %0h expected %0h", {state_a, hit_a}, {ST_WAIT_CLEAR, 1'b0});
    end
    tick(1);
    checks++;
    if (state_a !== ST_ARMED) begin
      errors++; $display("FAIL basic_armed: got %0d expected %0d", state_a, ST_ARMED);
    end
    photo_array[5] = 1'b1;
    tick(6);
    checks++;
    if ({photo_clean[5], hit_a, hit_pulse_a} !== 3'b100) begin
      errors++; $display("FAIL basic_pre_hit: got %0b expected 100", {photo_clean[5], hit_a, hit_pulse_a});
    end
    tick(1);
    checks++;
    if ({hit_pulse_a, hit_a, state_a} !== {1'b1, 1'b1, ST_HIT}) begin
      errors++; $display("FAIL basic_hit: got %0h expected %0h", {hit_pulse_a, hit_a, state_a}, {1'b1, 1'b1, ST_HIT});
    end
    tick(1);
    checks++;
    if ({hit_pulse_a, hit_a} !== 2'b01) begin
      errors++; $display("FAIL basic_pulse_width: got %0b expected 01", {hit_pulse_a, hit_a});
    end
    photo_array[5] = 1'b0;
    tick(8);
    checks++;
    if ({photo_clean[5], hit_a} !== 2'b01) begin
      errors++; $display("FAIL basic_hold: got %0b expected 01", {photo_clean[5], hit_a});
    end
    target_a = 4'd7;
    tick(1);
    checks++;
    if ({hit_a, state_a} !== {1'b0, ST_WAIT_CLEAR}) begin
      errors++; $display("FAIL basic_clear_on_change: got %0h expected %0h", {hit_a, state_a}, {1'b0, ST_WAIT_CLEAR});
    end
`ifdef HIT_COUNTER_EN
    checks++;
    if (total_hits !== 16'd1) begin
      errors++; $display("FAIL basic_total: got %0d expected 1", total_hits);
    end
`endif
  endtask

  task automatic test_pre_blocked();
    int npulse;
    photo_array[2] = 1'b1;
    tick(7);
    target_b = 4'd2;
    tick(5);
    checks++;
    if ({state_b, hit_b} !== {ST_WAIT_CLEAR, 1'b0}) begin
      errors++; $display("FAIL preblock_wait: got %0h expected %0h", {state_b, hit_b}, {ST_WAIT_CLEAR, 1'b0});
    end
    photo_array[2] = 1'b0;
    tick(7);
    checks++;
    if ({state_b, hit_b} !== {ST_ARMED, 1'b0}) begin
      errors++; $display("FAIL preblock_armed: got %0h expected %0h", {state_b, hit_b}, {ST_ARMED, 1'b0});
    end
    photo_array[2] = 1'b1;
    npulse = 0;
    repeat (8) begin tick(1); npulse += int'(hit_pulse_b); end
    checks++;
    if ({npulse, hit_b} !== {32'd1, 1'b1}) begin
      errors++; $display("FAIL preblock_hit: got pulses=%0d hit=%0b expected pulses=1 hit=1", npulse, hit_b);
    end
  endtask

  task automatic test_invalid_shared();
    int na, ca, cb;
    target_a = 4'd12;
    photo_array = '1;
    na = 0;
    repeat (8) begin tick(1); na += int'(hit_pulse_a); end
    checks++;
    if ({na, hit_a, state_a} !== {32'd0, 1'b0, ST_IDLE}) begin
      errors++; $display("FAIL invalid_target: got pulses=%0d hit=%0b state=%0d expected 0 0 0", na, hit_a, state_a);
    end
    photo_array = '0;
    tick(7);
    target_a = 4'd4; target_b = 4'd4;
    tick(2);
    checks++;
    if ({state_a, state_b, hit_b} !== {ST_ARMED, ST_ARMED, 1'b0}) begin
      errors++; $display("FAIL shared_armed: got %0h expected %0h", {state_a, state_b, hit_b}, {ST_ARMED, ST_ARMED, 1'b0});
    end
    photo_array[4] = 1'b1;
    ca = 0; cb = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (hit_pulse_a) ca = k;
      if (hit_pulse_b) cb = k;
    end
    checks++;
    if ({ca, cb} !== {32'd7, 32'd7} || {hit_a, hit_b} !== 2'b11) begin
      errors++; $display("FAIL shared_hit: got cycles %0d/%0d hits %0b%0b expected 7/7 11", ca, cb, hit_a, hit_b);
    end
`ifdef HIT_COUNTER_EN
    checks++;
    if (total_hits !== 16'd4) begin
      errors++; $display("FAIL shared_total: got %0d expected 4", total_hits);
    end
`endif
  endtask

  task automatic test_collision_reset();
    int na;
    photo_array = '0;
    tick(7);
    target_a = 4'd6;
    tick(2);
    photo_array[6] = 1'b1; photo_array[8] = 1'b1;
    tick(6);
    checks++;
    if ({state_a, photo_clean[6], photo_clean[8]} !== {ST_ARMED, 2'b11}) begin
      errors++; $display("FAIL collision_setup: got %0h expected %0h", {state_a, photo_clean[6], photo_clean[8]}, {ST_ARMED, 2'b11});
    end
    target_a = 4'd8;
    na = 0;
    repeat (4) begin tick(1); na += int'(hit_pulse_a); end
    checks++;
    if ({na, hit_a, state_a} !== {32'd0, 1'b0, ST_WAIT_CLEAR}) begin
      errors++; $display("FAIL collision: got pulses=%0d hit=%0b state=%0d expected 0 0 1", na, hit_a, state_a);
    end
    checks++;
    if ({hit_b, state_b} !== {1'b1, ST_HIT}) begin
      errors++; $display("FAIL hit_before_reset: got %0h expected %0h", {hit_b, state_b}, {1'b1, ST_HIT});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({hit_a, hit_b, hit_pulse_a, hit_pulse_b, state_a, state_b, photo_clean} !== '0) begin
      errors++; $display("FAIL async_reset: got %0h expected 0", {hit_a, hit_b, hit_pulse_a, hit_pulse_b, state_a, state_b, photo_clean});
    end
`ifdef HIT_COUNTER_EN
    checks++;
    if (total_hits !== 16'd0) begin
      errors++; $display("FAIL async_reset_total: got %0d expected 0", total_hits);
    end
`endif
    target_a = 4'd3; target_b = 4'd0; photo_array = '0;
    @(negedge clock);
    reset = 1'b1;
    tick(1);
    checks++;
    if ({state_a, state_b} !== {ST_WAIT_CLEAR, ST_IDLE}) begin
      errors++; $display("FAIL post_reset_change: got %0h expected %0h", {state_a, state_b}, {ST_WAIT_CLEAR, ST_IDLE});
    end
  endtask

`ifdef HIT_COUNTER_EN
  task automatic test_saturation();
    int na;
    target_b = 4'd3;
    tick(2);
    force dut.total_hits = 16'hFFFE;
    tick(1);
    release dut.total_hits;
    tick(1);
    checks++;
    if (total_hits !== 16'hFFFE) begin
      errors++; $display("FAIL sat_preload: got %0h expected fffe", total_hits);
    end
    photo_array[3] = 1'b1;
    tick(8);
    checks++;
    if (total_hits !== 16'hFFFF) begin
      errors++; $display("FAIL sat_first: got %0h expected ffff", total_hits);
    end
    photo_array = '0;
    tick(7);
    target_a = 4'd5; target_b = 4'd5;
    tick(2);
    photo_array[5] = 1'b1;
    na = 0;
    repeat (9) begin tick(1); na += int'(hit_pulse_a); end
    checks++;
    if ({na, total_hits} !== {32'd1, 16'hFFFF}) begin
      errors++; $display("FAIL sat_hold: got pulses=%0d total=%0h expected 1 ffff", na, total_hits);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_debounce();
    test_basic_hit();
    test_pre_blocked();
    test_invalid_shared();
    test_collision_reset();
`ifdef HIT_COUNTER_EN
    test_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
